vga_sync_decoder: RTL and testbench

Receive-side counterpart to the VGA sync generator. Takes the active-area-style HSync/VSync pair produced upstream and recovers the column/row position of every pixel. It checks the incoming timing against the configured frame geometry and reports lock status. It sits between any sync source and the pattern/game logic, so downstream blocks can be driven from sync signals alone instead of shared counters.

---
 rtl/vga_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/vga_sync_decoder.sv | 130 +++++++++++++
 tb/tb_vga_sync_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and decoder state encoding.
package vga_pkg;

  localparam int unsigned CNT_W            = 10;
  localparam int unsigned DEF_TOTAL_COLS   = 800;
  localparam int unsigned DEF_TOTAL_ROWS   = 525;
  localparam int unsigned DEF_ACTIVE_COLS  = 640;
  localparam int unsigned DEF_ACTIVE_ROWS  = 480;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a 1-bit sync input; emits the delayed level and rise/fall pulses.
module sync_edge_detect (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  // primed stays low for the first sample after reset, so a line already
  // high when reset releases is not mistaken for a rising edge.
  logic primed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      level  <= 1'b0;
      primed <= 1'b0;
    end else begin
      level  <= sig;
      primed <= 1'b1;
    end
  end

  assign rise = primed &  sig & ~level;
  assign fall = primed & ~sig &  level;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel column/row from an HSync/VSync pair and tracks timing lock.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Frame_Start,
  output logic             o_Locked,
  output logic             o_Sync_Err
);

  localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);

  logic h_rise, h_fall, v_rise, v_fall;
  logic unused_edges;

  sync_edge_detect u_hsync (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .sig    (i_HSync),
    .level  (o_HSync),
    .rise   (h_rise),
    .fall   (h_fall)
  );

  sync_edge_detect u_vsync (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .sig    (i_VSync),
    .level  (o_VSync),
    .rise   (v_rise),
    .fall   (v_fall)
  );

  assign unused_edges = ^{h_rise, h_fall, v_fall};

  sync_state_t      state;
  logic [CNT_W-1:0] col, row;
  logic [CNT_W-1:0] fr_col, fr_row, p_col, p_row;
  logic [GOOD_W-1:0] good, good_inc;
  logic             exp_h, exp_v, misalign, err;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fr_col = col + 1'b1;
    fr_row = row;
    if (col == CNT_W'(TOTAL_COLS - 1)) begin
      fr_col = '0;
      fr_row = (row == CNT_W'(TOTAL_ROWS - 1)) ? '0 : row + 1'b1;
    end

    // Position of the incoming sample: pinned to the origin on a VSync rise
    // and while searching, otherwise the free-running successor.
    p_col = fr_col;
    p_row = fr_row;
    if (v_rise || state == SEARCH) begin
      p_col = '0;
      p_row = '0;
    end

    exp_h    = (p_col < CNT_W'(ACTIVE_COLS));
    exp_v    = (p_row < CNT_W'(ACTIVE_ROWS));
    misalign = v_rise && ((fr_col != '0) || (fr_row != '0));
    err      = (state != SEARCH) &&
               ((i_HSync != exp_h) || (i_VSync != exp_v) || misalign);
    good_inc = good + 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= SEARCH;
      col           <= '0;
      row           <= '0;
      good          <= '0;
      o_Frame_Start <= 1'b0;
      o_Sync_Err    <= 1'b0;
      o_Locked      <= 1'b0;
    end else begin
      col           <= p_col;
      row           <= p_row;
      o_Frame_Start <= v_rise;
      o_Sync_Err    <= err;
      case (state)
        SEARCH: begin
          o_Locked <= 1'b0;
          if (v_rise) begin
            state <= LOCKING;
            good  <= '0;
          end
        end
        LOCKING, LOCKED: begin
          if (err) begin
            // An erroneous rise realigns in place; any other error drops out.
            state    <= v_rise ? LOCKING : SEARCH;
            good     <= '0;
            o_Locked <= 1'b0;
          end else if (v_rise && state == LOCKING) begin
            good <= good_inc;
            if (32'(good_inc) >= LOCK_FRAMES) begin
              state    <= LOCKED;
              o_Locked <= 1'b1;
            end
          end
        end
        default: begin
          state    <= SEARCH;
          good     <= '0;
          o_Locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_Col_Count = col;
  assign o_Row_Count = row;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 24x14 frame geometry.
module tb_vga_sync_decoder;

  localparam int TC    = 24;
  localparam int TR    = 14;
  localparam int AC    = 16;
  localparam int AR    = 10;
  localparam int LF    = 2;
  localparam int FRAME = TC * TR;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_HSync = 1'b0;
  logic       i_VSync = 1'b0;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Sync_Err;
  logic [9:0] o_Col_Count, o_Row_Count;

  int checks = 0;
  int failures = 0;
  int src_col = 0;
  int src_row = 0;
  int n_err = 0;
  int n_fs = 0;
  int pos_bad = 0;
  bit track_pos = 1'b0;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (i_Reset),
    .i_HSync      (i_HSync),
    .i_VSync      (i_VSync),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Frame_Start(o_Frame_Start),
    .o_Locked     (o_Locked),
    .o_Sync_Err   (o_Sync_Err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one sample; outputs for it are visible on return.
  task automatic cyc(input logic h, input logic v);
    @(negedge clk);
    i_HSync = h;
    i_VSync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic src_adv();
    if (src_col == TC - 1) begin
      src_col = 0;
      src_row = (src_row == TR - 1) ? 0 : src_row + 1;
    end else begin
      src_col++;
    end
  endtask

  task automatic src_pixel();
    cyc(src_col < AC, src_row < AR);
    if (track_pos && (int'(o_Col_Count) != src_col || int'(o_Row_Count) != src_row)) pos_bad++;
    if (o_Sync_Err) n_err++;
    if (o_Frame_Start) n_fs++;
    src_adv();
  endtask

  task automatic run_to(input int row, input int col);
    for (int n = 0; n < FRAME + 2; n++) begin
      if (src_row == row && src_col == col) break;
      src_pixel();
    end
  endtask

  // Two clean frames after a realigning rise must restore lock.
  task automatic relock();
    n_err = 0;
    repeat (FRAME) src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked} !== 2'b10) begin
      failures++;
      $display("FAIL relock_first: fs/locked=%b expected 10", {o_Frame_Start, o_Locked});
    end
    repeat (FRAME) src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked} !== 2'b11 || n_err != 0) begin
      failures++;
      $display("FAIL relock_second: fs/locked=%b errs=%0d expected 11 and 0",
               {o_Frame_Start, o_Locked}, n_err);
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    checks++;
    if ({o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Sync_Err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Sync_Err});
    end
    checks++;
    if ({o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL reset_counts: col=%0d row=%0d expected 0,0", o_Col_Count, o_Row_Count);
    end
    i_Reset = 1'b0;
    src_row = TR - 1;
    src_col = 0;
  endtask

  task automatic test_lock();
    n_fs = 0;
    n_err = 0;
    track_pos = 1'b0;
    src_pixel();
    checks++;
    if ({o_HSync, o_VSync} !== 2'b10) begin
      failures++;
      $display("FAIL sync_delay: hs/vs=%b expected 10", {o_HSync, o_VSync});
    end
    run_to(0, 0);
    checks++;
    if (n_fs != 0 || n_err != 0 || {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL search_idle: fs=%0d err=%0d col=%0d row=%0d expected 0s",
               n_fs, n_err, o_Col_Count, o_Row_Count);
    end
    src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked, o_Sync_Err} !== 3'b100 || {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL first_frame_start: fs/lk/err=%b col=%0d row=%0d expected 100 at 0,0",
               {o_Frame_Start, o_Locked, o_Sync_Err}, o_Col_Count, o_Row_Count);
    end
    track_pos = 1'b1;
    repeat (FRAME) src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked} !== 2'b10) begin
      failures++;
      $display("FAIL second_frame_start: fs/locked=%b expected 10", {o_Frame_Start, o_Locked});
    end
    repeat (FRAME - 1) src_pixel();
    checks++;
    if (o_Locked !== 1'b0) begin
      failures++;
      $display("FAIL early_lock: locked=%b expected 0", o_Locked);
    end
    src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked} !== 2'b11) begin
      failures++;
      $display("FAIL third_frame_lock: fs/locked=%b expected 11", {o_Frame_Start, o_Locked});
    end
    n_err = 0;
    repeat (5 * FRAME) src_pixel();
    checks++;
    if (n_err != 0 || o_Locked !== 1'b1 || pos_bad != 0) begin
      failures++;
      $display("FAIL five_clean_frames: errs=%0d locked=%b pos_bad=%0d expected 0,1,0",
               n_err, o_Locked, pos_bad);
    end
  endtask

  task automatic test_counter_walk();
    run_to(10, TC - 1);
    src_pixel();
    checks++;
    if (o_Col_Count !== 10'(TC - 1) || o_Row_Count !== 10'd10) begin
      failures++;
      $display("FAIL walk_line_end: col=%0d row=%0d expected %0d,10", o_Col_Count, o_Row_Count, TC - 1);
    end
    src_pixel();
    checks++;
    if (o_Col_Count !== 10'd0 || o_Row_Count !== 10'd11) begin
      failures++;
      $display("FAIL walk_line_wrap: col=%0d row=%0d expected 0,11", o_Col_Count, o_Row_Count);
    end
    run_to(TR - 1, TC - 1);
    src_pixel();
    checks++;
    if (o_Col_Count !== 10'(TC - 1) || o_Row_Count !== 10'(TR - 1) || o_Frame_Start !== 1'b0) begin
      failures++;
      $display("FAIL walk_frame_end: col=%0d row=%0d fs=%b expected %0d,%0d,0",
               o_Col_Count, o_Row_Count, o_Frame_Start, TC - 1, TR - 1);
    end
    src_pixel();
    checks++;
    if ({o_Col_Count, o_Row_Count} !== 20'd0 || {o_Frame_Start, o_Locked, o_Sync_Err} !== 3'b110) begin
      failures++;
      $display("FAIL walk_frame_wrap: col=%0d row=%0d fs/lk/err=%b expected 0,0,110",
               o_Col_Count, o_Row_Count, {o_Frame_Start, o_Locked, o_Sync_Err});
    end
  endtask

  task automatic test_hsync_extend();
    run_to(2, AC);
    track_pos = 1'b0;
    cyc(1'b1, 1'b1);
    src_adv();
    checks++;
    if ({o_Sync_Err, o_Locked} !== 2'b10 || o_Col_Count !== 10'(AC) || o_Row_Count !== 10'd2) begin
      failures++;
      $display("FAIL hs_extend_err: err/locked=%b col=%0d row=%0d expected 10,%0d,2",
               {o_Sync_Err, o_Locked}, o_Col_Count, o_Row_Count, AC);
    end
    src_pixel();
    checks++;
    if (o_Sync_Err !== 1'b0 || {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL hs_extend_search: err=%b col=%0d row=%0d expected 0,0,0",
               o_Sync_Err, o_Col_Count, o_Row_Count);
    end
    n_err = 0;
    n_fs = 0;
    run_to(0, 0);
    checks++;
    if (n_err != 0 || n_fs != 0 || {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL hs_extend_idle: errs=%0d fs=%0d col=%0d row=%0d expected 0s",
               n_err, n_fs, o_Col_Count, o_Row_Count);
    end
    src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked} !== 2'b10) begin
      failures++;
      $display("FAIL hs_extend_reacquire: fs/locked=%b expected 10", {o_Frame_Start, o_Locked});
    end
    track_pos = 1'b1;
    relock();
  endtask

  task automatic test_early_vsync();
    run_to(12, 5);
    src_row = 0;
    src_col = 0;
    src_pixel();
    checks++;
    if ({o_Sync_Err, o_Frame_Start, o_Locked} !== 3'b110 || {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL early_vsync: err/fs/lk=%b col=%0d row=%0d expected 110 at 0,0",
               {o_Sync_Err, o_Frame_Start, o_Locked}, o_Col_Count, o_Row_Count);
    end
    relock();
  endtask

  task automatic test_reset_mid();
    run_to(3, 8);
    track_pos = 1'b0;
    i_Reset = 1'b1;
    src_pixel();
    checks++;
    if ({o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Sync_Err} !== 5'b0 ||
        {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL mid_reset: flags=%b col=%0d row=%0d expected all 0",
               {o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Sync_Err}, o_Col_Count, o_Row_Count);
    end
    i_Reset = 1'b0;
    n_fs = 0;
    n_err = 0;
    src_pixel();
    checks++;
    if ({o_VSync, o_Frame_Start} !== 2'b10) begin
      failures++;
      $display("FAIL release_vs_high: vs/fs=%b expected 10", {o_VSync, o_Frame_Start});
    end
    run_to(0, 0);
    checks++;
    if (n_fs != 0 || n_err != 0) begin
      failures++;
      $display("FAIL release_no_start: fs=%0d errs=%0d expected 0,0", n_fs, n_err);
    end
    src_pixel();
    checks++;
    if ({o_Frame_Start, o_Locked} !== 2'b10) begin
      failures++;
      $display("FAIL release_reacquire: fs/locked=%b expected 10", {o_Frame_Start, o_Locked});
    end
    track_pos = 1'b1;
    relock();
  endtask

  task automatic test_source_stops();
    run_to(11, AC);
    track_pos = 1'b0;
    n_err = 0;
    for (int i = 0; i < TC - AC; i++) begin
      cyc(1'b0, 1'b0);
      if (o_Sync_Err) n_err++;
    end
    checks++;
    if (n_err != 0 || o_Locked !== 1'b1) begin
      failures++;
      $display("FAIL stop_blanking: errs=%0d locked=%b expected 0,1", n_err, o_Locked);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if ({o_Sync_Err, o_Locked} !== 2'b10 || o_Col_Count !== 10'd0 || o_Row_Count !== 10'd12) begin
      failures++;
      $display("FAIL stop_first_err: err/locked=%b col=%0d row=%0d expected 10,0,12",
               {o_Sync_Err, o_Locked}, o_Col_Count, o_Row_Count);
    end
    n_err = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1'b0, 1'b0);
      if (o_Sync_Err) n_err++;
    end
    checks++;
    if (n_err != 0 || o_Locked !== 1'b0 || {o_Col_Count, o_Row_Count} !== 20'd0) begin
      failures++;
      $display("FAIL stop_search: errs=%0d locked=%b col=%0d row=%0d expected 0,0,0,0",
               n_err, o_Locked, o_Col_Count, o_Row_Count);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_counter_walk();
    test_hsync_extend();
    test_early_vsync();
    test_reset_mid();
    test_source_stops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
